// File: rtl/pll_underclock_seq_if.sv
// -----------------------------------------------------------------------------
// pll_underclock_seq_if
// PLL reconfiguration management bus (pll_cfg mgmt port) between the
// underclock sequencer and the PLL reconfig block.
//   mgmt_write       write strobe, held with address/data until accepted
//   mgmt_read        read strobe, held with address until accepted
//   mgmt_address     6-bit register address
//   mgmt_writedata   32-bit write payload
//   mgmt_waitrequest backpressure from the PLL reconfig block
//   mgmt_readdata    32-bit read data from the PLL reconfig block
// master: the sequencer side; slave: the PLL reconfig side.
// -----------------------------------------------------------------------------
interface pll_underclock_seq_if;
  logic        mgmt_write;
  logic        mgmt_read;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;
  logic [31:0] mgmt_readdata;

  modport master (
    output mgmt_write, mgmt_read, mgmt_address, mgmt_writedata,
    input  mgmt_waitrequest, mgmt_readdata
  );

  modport slave (
    input  mgmt_write, mgmt_read, mgmt_address, mgmt_writedata,
    output mgmt_waitrequest, mgmt_readdata
  );
endinterface

// File: rtl/pll_underclock_seq.sv
// -----------------------------------------------------------------------------
// pll_underclock_seq
// Sequences the PLL reconfiguration writes that move the 49.152 MHz core clock
// between native speed and the ~1% underclocked 60 Hz mode. Runs on the 50 MHz
// management clock.
//
// Optional feature macro: PLL_CFG_READBACK_EN
//   defined   -> after the start write, poll status (addr 1) until bit0=1 or
//                POLL_LIMIT reads have been made (sticky timeout_o).
//   undefined -> no polling; mgmt_read and timeout_o are constant 0.
//
// Ports
//   clk_50m_i        management clock
//   reset_ni         asynchronous active-low reset
//   underclock_req_i requested mode, asynchronous (1 = underclock)
//   mgmt             pll_cfg management bus (master modport)
//   busy_o           a reconfiguration sequence is in progress
//   applied_o        mode last fully applied (1 = underclock)
//   timeout_o        sticky status-poll timeout
// -----------------------------------------------------------------------------
module pll_underclock_seq #(
  parameter logic [31:0] FRAC_NATIVE = 32'd3639383488,
  parameter logic [31:0] FRAC_UNDER  = 32'd3262113561,
  parameter int unsigned GAP_CYCLES  = 3,
  parameter int unsigned POLL_LIMIT  = 1023
) (
  input  logic                        clk_50m_i,
  input  logic                        reset_ni,
  input  logic                        underclock_req_i,
  pll_underclock_seq_if.master        mgmt,
  output logic                        busy_o,
  output logic                        applied_o,
  output logic                        timeout_o
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR_MODE, ST_GAP, ST_WR_FRAC, ST_WR_START, ST_POLL, ST_DONE
  } state_e;

  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] POLL_LAST = 16'(POLL_LIMIT - 1);

  logic        s1_q, s2_q, s3_q;
  state_e      state_q, next_q;
  logic [15:0] gap_cnt_q;
  logic        target_q, busy_q, applied_q;
  logic        write_q;
  logic [5:0]  addr_q;
  logic [31:0] data_q;
  logic        unused_readdata_s;

  // The write that follows each accepted write once its gap has elapsed.
  function automatic state_e after_write(input state_e s);
    case (s)
      ST_WR_MODE:  return ST_WR_FRAC;
      ST_WR_FRAC:  return ST_WR_START;
`ifdef PLL_CFG_READBACK_EN
      ST_WR_START: return ST_POLL;
`else
      ST_WR_START: return ST_DONE;
`endif
      default:     return ST_IDLE;
    endcase
  endfunction

`ifdef PLL_CFG_READBACK_EN
  logic        read_q;
  logic [15:0] poll_cnt_q;
  logic        timeout_q;
`endif

  // Request synchronizer; s3 lags s2 so a level must persist two samples to count.
  always_ff @(posedge clk_50m_i or negedge reset_ni) begin
    if (!reset_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= underclock_req_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Sequencer FSM with registered bus outputs.
  always_ff @(posedge clk_50m_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      next_q    <= ST_IDLE;
      gap_cnt_q <= 16'd0;
      target_q  <= 1'b0;
      busy_q    <= 1'b0;
      applied_q <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= 6'd0;
      data_q    <= 32'd0;
`ifdef PLL_CFG_READBACK_EN
      read_q     <= 1'b0;
      poll_cnt_q <= 16'd0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if ((s2_q == s3_q) && (s2_q != applied_q)) begin
            target_q <= s2_q;
            busy_q   <= 1'b1;
            write_q  <= 1'b1;
            addr_q   <= 6'd0;
            data_q   <= 32'd0;
            state_q  <= ST_WR_MODE;
          end
        end
        ST_WR_MODE, ST_WR_FRAC, ST_WR_START: begin
          // Payload stays frozen while the PLL holds waitrequest.
          if (!mgmt.mgmt_waitrequest) begin
            write_q   <= 1'b0;
            addr_q    <= 6'd0;
            data_q    <= 32'd0;
            gap_cnt_q <= GAP_LAST;
            next_q    <= after_write(state_q);
            state_q   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q != 16'd0) begin
            gap_cnt_q <= gap_cnt_q - 16'd1;
          end else begin
            state_q <= next_q;
            case (next_q)
              ST_WR_FRAC: begin
                write_q <= 1'b1;
                addr_q  <= 6'd7;
                data_q  <= target_q ? FRAC_UNDER : FRAC_NATIVE;
              end
              ST_WR_START: begin
                write_q <= 1'b1;
                addr_q  <= 6'd2;
                data_q  <= 32'd0;
              end
`ifdef PLL_CFG_READBACK_EN
              ST_POLL: begin
                read_q     <= 1'b1;
                addr_q     <= 6'd1;
                poll_cnt_q <= 16'd0;
              end
`endif
              default: begin
              end
            endcase
          end
        end
`ifdef PLL_CFG_READBACK_EN
        ST_POLL: begin
          if (read_q) begin
            if (!mgmt.mgmt_waitrequest) begin
              read_q <= 1'b0;
              addr_q <= 6'd0;
              if (mgmt.mgmt_readdata[0]) begin
                state_q <= ST_DONE;
              end else if (poll_cnt_q == POLL_LAST) begin
                timeout_q <= 1'b1;
                state_q   <= ST_DONE;
              end else begin
                poll_cnt_q <= poll_cnt_q + 16'd1;
              end
            end
          end else begin
            // One idle cycle between status reads.
            read_q <= 1'b1;
            addr_q <= 6'd1;
          end
        end
`endif
        ST_DONE: begin
          applied_q <= target_q;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mgmt.mgmt_write     = write_q;
  assign mgmt.mgmt_address   = addr_q;
  assign mgmt.mgmt_writedata = data_q;
  assign busy_o              = busy_q;
  assign applied_o           = applied_q;

`ifdef PLL_CFG_READBACK_EN
  assign mgmt.mgmt_read  = read_q;
  assign timeout_o       = timeout_q;
  assign unused_readdata_s = ^mgmt.mgmt_readdata[31:1];
`else
  assign mgmt.mgmt_read  = 1'b0;
  assign timeout_o       = 1'b0;
  assign unused_readdata_s = ^mgmt.mgmt_readdata;
`endif

endmodule

// File: tb/tb_pll_underclock_seq.sv
module tb_pll_underclock_seq;
  localparam logic [31:0] F_NAT = 32'd3639383488;
  localparam logic [31:0] F_UND = 32'd3262113561;
  localparam int GAP = 3;
  localparam int POLL_LIMIT = 1023;

  logic clk = 1'b0;
  logic rst_n;
  logic req;
  logic busy, applied, timeout;
  logic rnd_wr;
  logic rd_ok_en;
  int   rd_ok_after;
  int   rd_done = 0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  pll_underclock_seq_if bus();

  pll_underclock_seq dut (
    .clk_50m_i        (clk),
    .reset_ni         (rst_n),
    .underclock_req_i (req),
    .mgmt             (bus),
    .busy_o           (busy),
    .applied_o        (applied),
    .timeout_o        (timeout)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Status register model: bit0 reads 1 once rd_ok_after reads have completed.
  always @(posedge clk) if (bus.mgmt_read && !bus.mgmt_waitrequest) rd_done <= rd_done + 1;
  assign bus.mgmt_readdata = {31'd0, (rd_ok_en && (rd_done >= rd_ok_after))};

  // Bus monitor: strobe rises, accepted writes, payload changes during stalls.
  int        rise_cyc[$];
  int        acc_cyc[$];
  logic [5:0]  acc_addr[$];
  logic [31:0] acc_data[$];
  int        stall_bad = 0;
  logic        prev_w = 1'b0;
  logic [5:0]  prev_a = 6'd0;
  logic [31:0] prev_d = 32'd0;
  always @(negedge clk) begin
    if (bus.mgmt_write && !prev_w) rise_cyc.push_back(cyc);
    if (bus.mgmt_write && prev_w && ((bus.mgmt_address != prev_a) || (bus.mgmt_writedata != prev_d)))
      stall_bad++;
    if (bus.mgmt_write && !bus.mgmt_waitrequest) begin
      acc_cyc.push_back(cyc);
      acc_addr.push_back(bus.mgmt_address);
      acc_data.push_back(bus.mgmt_writedata);
    end
    prev_w = bus.mgmt_write;
    prev_a = bus.mgmt_address;
    prev_d = bus.mgmt_writedata;
  end

  // Reference: the three writes of a sequence towards a given target mode.
  function automatic logic [5:0] exp_addr(input int idx);
    logic [5:0] a [3];
    a[0] = 6'd0; a[1] = 6'd7; a[2] = 6'd2;
    return a[idx];
  endfunction

  function automatic logic [31:0] exp_data(input logic tgt, input int idx);
    if (idx == 1) return tgt ? F_UND : F_NAT;
    return 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_wr) bus.mgmt_waitrequest = ($urandom_range(0, 2) == 0);
  endtask

  task automatic wait_quiet(input int budget, output bit ok);
    int q;
    q = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (busy) q = 0; else q++;
      if (q >= 12) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; rnd_wr = 1'b0; bus.mgmt_waitrequest = 1'b0;
    rd_ok_en = 1'b1; rd_ok_after = 0;
    repeat (3) tick();
    total++; if ({bus.mgmt_write, bus.mgmt_read} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b want=00", {bus.mgmt_write, bus.mgmt_read}); end
    total++; if (bus.mgmt_address !== 6'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", bus.mgmt_address); end
    total++; if (bus.mgmt_writedata !== 32'd0) begin bad++; $display("FAIL reset_data got=%0d want=0", bus.mgmt_writedata); end
    total++; if ({busy, applied, timeout} !== 3'b000) begin bad++; $display("FAIL reset_status got=%b want=000", {busy, applied, timeout}); end
    rst_n = 1'b1;
    begin
      int r0, busy_seen;
      r0 = rise_cyc.size(); busy_seen = 0;
      repeat (100) begin tick(); if (busy || bus.mgmt_read) busy_seen++; end
      total++; if (rise_cyc.size() !== r0) begin bad++; $display("FAIL idle_no_strobe got=%0d want=%0d", rise_cyc.size(), r0); end
      total++; if (busy_seen !== 0) begin bad++; $display("FAIL idle_busy got=%0d want=0", busy_seen); end
      total++; if (applied !== 1'b0) begin bad++; $display("FAIL idle_applied got=%b want=0", applied); end
    end
  endtask

  task automatic test_underclock();
    int b, r, c0; bit ok;
    b = acc_cyc.size(); r = rise_cyc.size(); c0 = cyc;
    req = 1'b1;
    wait_quiet(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL uc_settle got=busy want=idle"); end
    total++; if (acc_cyc.size() - b !== 3) begin bad++; $display("FAIL uc_write_count got=%0d want=3", acc_cyc.size() - b); end
    if (acc_cyc.size() - b == 3 && rise_cyc.size() - r == 3) begin
      for (int i = 0; i < 3; i++) begin
        total++; if (acc_addr[b+i] !== exp_addr(i)) begin bad++; $display("FAIL uc_addr%0d got=%0d want=%0d", i, acc_addr[b+i], exp_addr(i)); end
        total++; if (acc_data[b+i] !== exp_data(1'b1, i)) begin bad++; $display("FAIL uc_data%0d got=%0d want=%0d", i, acc_data[b+i], exp_data(1'b1, i)); end
      end
      for (int i = 1; i < 3; i++) begin
        total++; if (rise_cyc[r+i] - acc_cyc[b+i-1] !== GAP + 1) begin bad++; $display("FAIL uc_gap%0d got=%0d want=%0d", i, rise_cyc[r+i] - acc_cyc[b+i-1], GAP + 1); end
      end
      total++; if (rise_cyc[r] - c0 < 3 || rise_cyc[r] - c0 > 5) begin bad++; $display("FAIL uc_latency got=%0d want=3..5", rise_cyc[r] - c0); end
    end
    total++; if ({applied, busy} !== 2'b10) begin bad++; $display("FAIL uc_final got=%b want=10", {applied, busy}); end
  endtask

  task automatic test_stall();
    int b, r, held; bit ok, found;
    b = acc_cyc.size(); r = rise_cyc.size(); held = 0; found = 1'b0;
    req = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (acc_cyc.size() >= b + 1 && bus.mgmt_write && bus.mgmt_address == 6'd7) begin found = 1'b1; break; end
    end
    total++; if (!found) begin bad++; $display("FAIL stall_find got=none want=write2"); end
    bus.mgmt_waitrequest = 1'b1;
    repeat (20) begin
      tick();
      if (bus.mgmt_write && bus.mgmt_address == 6'd7 && bus.mgmt_writedata == F_NAT) held++;
    end
    bus.mgmt_waitrequest = 1'b0;
    wait_quiet(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_settle got=busy want=idle"); end
    total++; if (held !== 20) begin bad++; $display("FAIL stall_held got=%0d want=20", held); end
    total++; if (stall_bad !== 0) begin bad++; $display("FAIL stall_payload_change got=%0d want=0", stall_bad); end
    total++; if (acc_cyc.size() - b !== 3) begin bad++; $display("FAIL stall_count got=%0d want=3", acc_cyc.size() - b); end
    if (acc_cyc.size() - b == 3 && rise_cyc.size() - r == 3) begin
      total++; if (acc_data[b+1] !== F_NAT) begin bad++; $display("FAIL stall_frac got=%0d want=%0d", acc_data[b+1], F_NAT); end
      total++; if (acc_cyc[b+2] - rise_cyc[r] !== 2 * (GAP + 1) + 20) begin bad++; $display("FAIL stall_span got=%0d want=%0d", acc_cyc[b+2] - rise_cyc[r], 2 * (GAP + 1) + 20); end
    end
    total++; if (applied !== 1'b0) begin bad++; $display("FAIL stall_applied got=%b want=0", applied); end
  endtask

  task automatic test_mid_change();
    int b; bit ok, seen;
    b = acc_cyc.size(); seen = 1'b0;
    req = 1'b1;
    for (int i = 0; i < 20; i++) begin tick(); if (busy) begin seen = 1'b1; break; end end
    total++; if (!seen) begin bad++; $display("FAIL mid_start got=idle want=busy"); end
    tick();
    req = 1'b0;
    wait_quiet(500, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_settle got=busy want=idle"); end
    total++; if (acc_cyc.size() - b !== 6) begin bad++; $display("FAIL mid_count got=%0d want=6", acc_cyc.size() - b); end
    if (acc_cyc.size() - b == 6) begin
      total++; if (acc_data[b+1] !== F_UND) begin bad++; $display("FAIL mid_first_frac got=%0d want=%0d", acc_data[b+1], F_UND); end
      total++; if (acc_data[b+4] !== F_NAT) begin bad++; $display("FAIL mid_second_frac got=%0d want=%0d", acc_data[b+4], F_NAT); end
    end
    total++; if (applied !== 1'b0) begin bad++; $display("FAIL mid_applied got=%b want=0", applied); end
  endtask

  task automatic test_glitch();
    int r;
    r = rise_cyc.size();
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (30) tick();
    total++; if (rise_cyc.size() !== r) begin bad++; $display("FAIL glitch_strobes got=%0d want=%0d", rise_cyc.size(), r); end
    total++; if ({busy, applied} !== 2'b00) begin bad++; $display("FAIL glitch_status got=%b want=00", {busy, applied}); end
  endtask

  task automatic test_random();
    int b, r, n, e_addr, e_gap, e_alt; bit ok; logic prev, last, tgt;
    b = acc_cyc.size(); r = rise_cyc.size();
    prev = applied; last = req;
    e_addr = 0; e_gap = 0; e_alt = 0;
    rnd_wr = 1'b1;
    for (int it = 0; it < 40; it++) begin
      req = $urandom_range(0, 1);
      last = req;
      repeat ($urandom_range(1, 40)) tick();
    end
    wait_quiet(3000, ok);
    rnd_wr = 1'b0;
    bus.mgmt_waitrequest = 1'b0;
    n = acc_cyc.size() - b;
    total++; if (!ok) begin bad++; $display("FAIL rnd_settle got=busy want=idle"); end
    total++; if (n % 3 !== 0 || rise_cyc.size() - r !== n) begin bad++; $display("FAIL rnd_count got=%0d rises=%0d want=multiple of 3", n, rise_cyc.size() - r); end
    if (n % 3 == 0 && rise_cyc.size() - r == n) begin
      for (int j = 0; j < n / 3; j++) begin
        tgt = (acc_data[b+3*j+1] == F_UND);
        for (int i = 0; i < 3; i++) begin
          if (acc_addr[b+3*j+i] !== exp_addr(i) || acc_data[b+3*j+i] !== exp_data(tgt, i)) e_addr++;
          if (i > 0 && rise_cyc[r+3*j+i] - acc_cyc[b+3*j+i-1] != GAP + 1) e_gap++;
        end
        if (tgt == prev) e_alt++;
        prev = tgt;
      end
      total++; if (e_addr !== 0) begin bad++; $display("FAIL rnd_payload got=%0d bad writes want=0", e_addr); end
      total++; if (e_gap !== 0) begin bad++; $display("FAIL rnd_gap got=%0d bad gaps want=0", e_gap); end
      total++; if (e_alt !== 0) begin bad++; $display("FAIL rnd_alternation got=%0d want=0", e_alt); end
    end
    total++; if (stall_bad !== 0) begin bad++; $display("FAIL rnd_stall_payload got=%0d want=0", stall_bad); end
    total++; if (applied !== last) begin bad++; $display("FAIL rnd_last_wins got=%b want=%b", applied, last); end
  endtask

`ifdef PLL_CFG_READBACK_EN
  task automatic test_readback();
    int base; bit ok; logic want;
    base = rd_done; rd_ok_after = rd_done + 5; want = ~applied;
    req = want;
    wait_quiet(600, ok);
    total++; if (!ok) begin bad++; $display("FAIL rb_settle got=busy want=idle"); end
    total++; if (rd_done - base !== 6) begin bad++; $display("FAIL rb_reads got=%0d want=6", rd_done - base); end
    total++; if ({applied, timeout} !== {want, 1'b0}) begin bad++; $display("FAIL rb_status got=%b want=%b0", {applied, timeout}, want); end
  endtask

  task automatic test_timeout();
    int base; bit ok; logic want;
    base = rd_done; rd_ok_en = 1'b0; want = ~applied;
    req = want;
    wait_quiet(6000, ok);
    total++; if (!ok) begin bad++; $display("FAIL to_settle got=busy want=idle"); end
    total++; if (rd_done - base !== POLL_LIMIT) begin bad++; $display("FAIL to_reads got=%0d want=%0d", rd_done - base, POLL_LIMIT); end
    total++; if ({applied, timeout} !== {want, 1'b1}) begin bad++; $display("FAIL to_status got=%b want=%b1", {applied, timeout}, want); end
    rd_ok_en = 1'b1; rd_ok_after = 0;
  endtask
`endif

  task automatic test_reset_stall();
    int r; bit found;
    found = 1'b0;
    req = ~applied;
    for (int i = 0; i < 20; i++) begin tick(); if (bus.mgmt_write) begin found = 1'b1; break; end end
    bus.mgmt_waitrequest = 1'b1;
    repeat (5) tick();
    total++; if (!found || !bus.mgmt_write) begin bad++; $display("FAIL rs_stalled got=%b want=1", bus.mgmt_write); end
    r = rise_cyc.size();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if ({bus.mgmt_write, bus.mgmt_read, busy, applied, timeout} !== 5'b00000) begin bad++; $display("FAIL rs_async got=%b want=00000", {bus.mgmt_write, bus.mgmt_read, busy, applied, timeout}); end
    total++; if ({bus.mgmt_address, bus.mgmt_writedata} !== 38'd0) begin bad++; $display("FAIL rs_payload got=%0d want=0", bus.mgmt_writedata); end
    req = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    bus.mgmt_waitrequest = 1'b0;
    repeat (30) tick();
    total++; if (rise_cyc.size() !== r) begin bad++; $display("FAIL rs_no_retry got=%0d want=%0d", rise_cyc.size(), r); end
    total++; if ({busy, applied} !== 2'b00) begin bad++; $display("FAIL rs_after got=%b want=00", {busy, applied}); end
  endtask

  initial begin
    test_reset();
    test_underclock();
    test_stall();
    test_mid_change();
    test_glitch();
    test_random();
`ifdef PLL_CFG_READBACK_EN
    test_readback();
    test_timeout();
`endif
    test_reset_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
